// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner: FSM states,
// frame classification and the {row,col} -> hex code keymap.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        FRAME_NONE,
        FRAME_ONE,
        FRAME_MULTI
    } frame_class_t;

    // Indexed by {row[1:0], col[1:0]}; listed from index 15 down to 0.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hE, 4'hF, 4'h0,   // row 3, col 3..0
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1
        4'hA, 4'h3, 4'h2, 4'h1    // row 0
    };

    // Classify a frame of 16 key hits into none / exactly one / several.
    function automatic frame_class_t classify_frame(input logic [15:0] hits);
        if (hits == 16'h0000)
            return FRAME_NONE;
        else if ((hits & (hits - 16'd1)) == 16'h0000)
            return FRAME_ONE;
        else
            return FRAME_MULTI;
    endfunction

    // Position of the lowest set hit; only meaningful for a single-hit frame.
    function automatic logic [3:0] hit_index(input logic [15:0] hits);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (hits[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_controller_tick.sv
// Column-step divider: one-cycle tick every SCAN_DIV clocks.
module key_scan_tick #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    // Free-running 0..SCAN_DIV-1 counter.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_controller.sv
// 4x4 hex keypad scanner: strobes columns, debounces whole frames and
// shifts each accepted key into a 16-bit entry register.
module keypad_controller
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entry,
    output logic        key_held
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic [3:0]   row_meta;
    logic [3:0]   row_sync;
    logic         tick;
    logic [1:0]   ci;
    logic [15:0]  acc;
    logic [15:0]  col_hits;
    logic [15:0]  frame_bits;
    logic         frame_close;
    frame_class_t fclass;
    logic [3:0]   fcode;
    state_t       state;
    logic [3:0]   cand;
    logic [3:0]   cnt;
    logic [3:0]   cnt_inc;

    key_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous row lines.
    // NOTE: non-blocking assignments make row_sync take the old row_meta, giving two real stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign col = ~(4'b0001 << ci);

    // Map the active-low rows seen on the current column into frame positions.
    // NOTE: the default before the loop keeps this purely combinational (no latch).
    always_comb begin
        col_hits = '0;
        for (int r = 0; r < 4; r++) begin
            col_hits[r*4 + int'(ci)] = ~row_sync[r];
        end
    end

    assign frame_bits  = acc | col_hits;
    assign frame_close = tick && (ci == 2'd3);
    assign fclass      = classify_frame(frame_bits);
    assign fcode       = KEYMAP[hit_index(frame_bits)];
    assign cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    // Column stepping and frame accumulation; cleared at each frame close.
    always_ff @(posedge clk) begin
        if (reset) begin
            ci  <= 2'd0;
            acc <= '0;
        end else if (tick) begin
            ci  <= ci + 2'd1;
            acc <= (ci == 2'd3) ? '0 : frame_bits;
        end
    end

    // Press/release debounce FSM, stepped once per closed frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cand      <= 4'd0;
            cnt       <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            entry     <= 16'd0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_close) begin
                unique case (state)
                    ST_IDLE: begin
                        if (fclass == FRAME_ONE) begin
                            cand <= fcode;
                            cnt  <= 4'd1;
                            if (DEB <= 4'd1) begin
                                key_valid <= 1'b1;
                                key_code  <= fcode;
                                entry     <= {entry[11:0], fcode};
                                key_held  <= 1'b1;
                                state     <= ST_HELD;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (fclass == FRAME_ONE) begin
                            if (fcode == cand) begin
                                cnt <= cnt_inc;
                                if (cnt_inc >= DEB) begin
                                    key_valid <= 1'b1;
                                    key_code  <= fcode;
                                    entry     <= {entry[11:0], fcode};
                                    key_held  <= 1'b1;
                                    state     <= ST_HELD;
                                end
                            end else begin
                                cand <= fcode;
                                cnt  <= 4'd1;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (fclass == FRAME_NONE) begin
                            cnt <= 4'd1;
                            if (DEB <= 4'd1) begin
                                key_held <= 1'b0;
                                state    <= ST_IDLE;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (fclass == FRAME_NONE) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DEB) begin
                                key_held <= 1'b0;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            state <= ST_HELD;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_controller.sv
// Directed bench for keypad_controller with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (one frame = 16 clocks). A small keypad model pulls rows low for the
// pressed keys on the strobed column.
module tb_keypad_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry;
    logic        key_held;

    logic [15:0] key_mask;   // pressed keys, bit index = row*4 + col
    int          pulses;
    int          n_checks;
    int          n_pass;
    int          base;

    keypad_controller #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .entry     (entry),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key sits on the low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    // Count every key_valid cycle.
    always @(posedge clk) begin
        if (!reset && key_valid) pulses = pulses + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Hand-written key positions {row, col}.
    function automatic logic [15:0] key_bit(input logic [3:0] code);
        int p;
        case (code)
            4'h1: p = 0;  4'h2: p = 1;  4'h3: p = 2;  4'hA: p = 3;
            4'h4: p = 4;  4'h5: p = 5;  4'h6: p = 6;  4'hB: p = 7;
            4'h7: p = 8;  4'h8: p = 9;  4'h9: p = 10; 4'hC: p = 11;
            4'h0: p = 12; 4'hF: p = 13; 4'hE: p = 14; default: p = 15;
        endcase
        return 16'(1) << p;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) cycles(16);
    endtask

    task automatic press_release(input logic [3:0] code, input int hold, input int rel);
        key_mask = key_bit(code);
        frames(hold);
        key_mask = 16'h0;
        frames(rel);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pulses   = 0;
        key_mask = 16'h0;
        reset    = 1'b1;
        cycles(3);

        // Reset state
        check("rst_col", 16'(col), 16'hE);
        check("rst_valid", 16'(key_valid), 16'h0);
        check("rst_code", 16'(key_code), 16'h0);
        check("rst_entry", entry, 16'h0000);
        check("rst_held", 16'(key_held), 16'h0);
        reset = 1'b0;

        // Column advances after one tick period
        cycles(4);
        check("col_step", 16'(col), 16'hD);
        cycles(12);

        // Basic press of key 5
        key_mask = key_bit(4'h5);
        frames(1);
        check("k5_no_early", 16'(key_valid), 16'h0);
        frames(1);
        check("k5_valid", 16'(key_valid), 16'h1);
        check("k5_code", 16'(key_code), 16'h5);
        check("k5_entry", entry, 16'h0005);
        check("k5_held", 16'(key_held), 16'h1);
        cycles(1);
        check("k5_pulse_width", 16'(key_valid), 16'h0);
        cycles(15);
        frames(1);
        check("k5_one_pulse", 16'(pulses), 16'd1);
        key_mask = 16'h0;
        frames(1);
        check("k5_rel1_held", 16'(key_held), 16'h1);
        frames(1);
        check("k5_rel2_held", 16'(key_held), 16'h0);
        frames(1);

        // Entry sequence A 3 0 F, then 1
        base = pulses;
        press_release(4'hA, 3, 3);
        press_release(4'h3, 3, 3);
        press_release(4'h0, 3, 3);
        press_release(4'hF, 3, 3);
        check("seq_pulses", 16'(pulses - base), 16'd4);
        check("seq_entry", entry, 16'hA30F);
        check("seq_code_kept", 16'(key_code), 16'hF);
        press_release(4'h1, 3, 3);
        check("seq_entry5", entry, 16'h30F1);

        // Bounce: 7, gap, 7, gap
        base = pulses;
        press_release(4'h7, 1, 1);
        press_release(4'h7, 1, 2);
        check("bounce_pulses", 16'(pulses - base), 16'd0);
        check("bounce_entry", entry, 16'h30F1);
        check("bounce_held", 16'(key_held), 16'h0);

        // Held D with a one-frame gap
        base = pulses;
        key_mask = key_bit(4'hD);
        frames(4);
        key_mask = 16'h0;
        frames(1);
        check("glitch_held", 16'(key_held), 16'h1);
        key_mask = key_bit(4'hD);
        frames(5);
        check("glitch_pulses", 16'(pulses - base), 16'd1);
        check("glitch_entry", entry, 16'h0F1D);
        key_mask = 16'h0;
        frames(2);
        check("glitch_released", 16'(key_held), 16'h0);

        // Multi-key from IDLE, then while HELD on 1
        base = pulses;
        key_mask = key_bit(4'h1) | key_bit(4'h2);
        frames(3);
        check("multi_idle_pulses", 16'(pulses - base), 16'd0);
        check("multi_idle_held", 16'(key_held), 16'h0);
        key_mask = key_bit(4'h1);
        frames(2);
        check("multi_k1_entry", entry, 16'hF1D1);
        key_mask = key_bit(4'h1) | key_bit(4'h2);
        frames(3);
        check("multi_held_pulses", 16'(pulses - base), 16'd1);
        check("multi_held_state", 16'(key_held), 16'h1);
        key_mask = 16'h0;
        frames(2);
        check("multi_released", 16'(key_held), 16'h0);
        check("multi_code", 16'(key_code), 16'h1);

        // Reset mid-frame with key 5 in debounce
        key_mask = key_bit(4'h5);
        frames(1);
        cycles(7);
        reset = 1'b1;
        cycles(1);
        check("mid_rst_col", 16'(col), 16'hE);
        check("mid_rst_entry", entry, 16'h0000);
        check("mid_rst_valid", 16'(key_valid), 16'h0);
        check("mid_rst_held", 16'(key_held), 16'h0);
        reset = 1'b0;
        base = pulses;
        frames(1);
        check("mid_rst_no_pulse", 16'(pulses - base), 16'd0);
        frames(1);
        check("mid_rst_valid2", 16'(key_valid), 16'h1);
        check("mid_rst_entry2", entry, 16'h0005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_controller.md
Name: keypad_controller

Overview:
- Input-side counterpart of the display controller: scans a 4x4 hex keypad with column strobes and reads the row lines, where the display drives anode strobes.
- Debounces each press and shifts the entered hex digit into a 16-bit entry register.
- The entry nibbles feed the display's ad_high/ad_low/d_high/d_low inputs and the memory address/data path.

Parameters:
- SCAN_DIV, 100000: clk cycles per column step (100 MHz -> 1 kHz column rate, 250 Hz frame rate).
- DEBOUNCE_SCANS, 4: consecutive identical frames required to accept a press or a release (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- row  input  4  keypad row lines, active-low (pulled up), asynchronous.
- col  output  4  keypad column strobes, active-low, exactly one low at a time.
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_code  output  4  hex code of the last accepted key; held between presses.
- entry  output  16  digit-entry register; [15:12]=ad_high, [11:8]=ad_low, [7:4]=d_high, [3:0]=d_low.
- key_held  output  1  high while the accepted key is considered down.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: col=4'b1110; key_valid=0; key_code=0; entry=0; key_held=0. Also cleared: tick counter, column index, frame accumulator, debounce counter; FSM goes to IDLE.
- Reset mid-operation (press in progress, mid-frame) discards everything; no key_valid pulse on the cycle reset is applied.
- Row synchronizer: row passes through a 2-flop synchronizer. Only the synchronized value is used.
- Tick: counter counts 0..SCAN_DIV-1 and wraps; tick=1 on the cycle the count equals SCAN_DIV-1.
- Scanning: column index ci runs 0..3 and wraps; col = ~(4'b0001 << ci).
- On each tick:
  - sample the synchronized row for column ci into the frame accumulator (row settled for a full tick period);
  - then advance ci.
- Frame close: on the tick that samples ci=3, the frame closes and the accumulator is cleared for the next frame.
- Frame classification:
  - NONE: no row low in any column.
  - ONE(code): exactly one (row, column) low.
  - MULTI: two or more low.
- Keymap, code[row r][col c] (row0/col0 = pin 0):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM, evaluated once per closed frame:
  - IDLE: ONE(k) -> cand=k, cnt=1, go to DEBOUNCE (if DEBOUNCE_SCANS=1, accept immediately, as below). NONE or MULTI -> stay.
  - DEBOUNCE:
    - ONE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - ONE(other) -> cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - Accept actions: key_valid=1 for exactly one clk, the cycle after the frame close; key_code=cand; entry={entry[11:0],cand}; key_held=1.
  - HELD:
    - NONE -> cnt=1, go to RELEASE.
    - ONE (any key) or MULTI -> stay. No auto-repeat, no second pulse.
  - RELEASE:
    - NONE -> cnt+1. When cnt reaches DEBOUNCE_SCANS, key_held=0 and go to IDLE.
    - Any key -> HELD.
- Latency: key_valid follows the DEBOUNCE_SCANS-th consecutive matching frame close by 1 clk.
- Arithmetic: cnt is 4 bits and saturates; entry shift drops bits [15:12]; no other arithmetic.

Decomposition:
- Shared package keypad_pkg:
  - FSM state typedef (IDLE, DEBOUNCE, HELD, RELEASE);
  - 16-entry KEYMAP constant indexed {row,col};
  - frame-class encoding (NONE/ONE/MULTI).
- Sub-module key_scan_tick: the SCAN_DIV divider producing the one-cycle tick, in the same role the LED clock divider plays for the display.

Test Plan:
- All benches use SCAN_DIV=4, DEBOUNCE_SCANS=2 (frame = 16 clk).
- Reset behaviour: assert reset mid-frame with key 5 held -> next cycle col=1110, entry=0, key_valid=0, no pulse afterwards until 2 fresh full frames.
- Basic press: hold row1 low whenever col1 strobes (key 5) for 3 frames -> one key_valid pulse 1 clk after the 2nd frame close; key_code=5, entry=0x0005, key_held=1.
- Entry sequence: press and release A, 3, 0, F (each held 3 frames, released 3 frames) -> exactly 4 pulses; entry=0xA30F. A 5th press of 1 -> entry=0x30F1.
- Bounce rejection: key 7 present for 1 frame, then NONE, then 7 again for 1 frame -> no key_valid; entry unchanged.
- Held and glitch: hold D for 10 frames with a 1-frame NONE gap at frame 5 -> single pulse; key_held stays 1 through the gap. After a 2-frame release, key_held=0.
- Multi-key: keys 1 and 2 pressed together from IDLE -> no pulse. Same combination while HELD on 1 -> remains HELD, no pulse.
